// File: rtl/dma_pkg.sv
// Shared types and defaults for the DMA datapath blocks.
package dma_pkg;

  localparam int DMA_DATA_WIDTH    = 32;
  localparam int DMA_FIFO_DEPTH    = 32;
  localparam int DMA_ARB_MAX_BURST = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } dma_arb_state_e;

  typedef logic [$clog2(DMA_FIFO_DEPTH):0] dma_fifo_lvl_t;

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping.
module dma_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(ptr_i) + i) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/dma_fifo_wr_arb.sv
// Write-side scheduler for the shared DMA data FIFO: round-robin burst grants,
// admitted only when a full MAX_BURST is guaranteed to fit.
module dma_fifo_wr_arb
  import dma_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int WIDTH        = DMA_DATA_WIDTH,
  parameter  int SLOTS        = DMA_FIFO_DEPTH,
  parameter  int MAX_BURST    = DMA_ARB_MAX_BURST,
  parameter  int AFULL_THRESH = SLOTS - 4,
  localparam int LW           = $clog2(SLOTS) + 1,
  localparam int IW           = $clog2(N_REQ),
  localparam int BW           = $clog2(MAX_BURST) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ-1:0]       req_last_i,
  input  logic [N_REQ*WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic                   fifo_write_o,
  output logic [WIDTH-1:0]       fifo_data_o,
  input  logic                   fifo_full_i,
  input  logic                   fifo_read_i,
  input  logic                   fifo_empty_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [LW-1:0]          level_o,
  output logic                   afull_o
);

  // state  | meaning
  // IDLE   | no owner; arbitrate when a whole burst fits
  // LOCKED | grant_q owns the write port until last beat or MAX_BURST
  dma_arb_state_e   state_q;
  logic [N_REQ-1:0] grant_q;
  logic [IW-1:0]    gidx_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [BW-1:0]    beat_cnt_q;
  logic [LW-1:0]    level_q, level_d;
  logic             afull_q;

  logic [WIDTH-1:0] req_lane [N_REQ];
  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;
  logic [LW:0]      start_sum;
  logic             start_ok;
  logic             locked;
  logic             rd_dec;
  logic             last_beat;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign req_lane[gi] = req_data_i[gi*WIDTH +: WIDTH];
  end

  dma_rr_pick #(.N(N_REQ)) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // One bit wider so level + MAX_BURST cannot wrap.
  assign start_sum = {1'b0, level_q} + (LW+1)'(MAX_BURST);
  assign start_ok  = (start_sum <= (LW+1)'(SLOTS));
  assign locked    = (state_q == LOCKED) && !clear_i;
  assign rd_dec    = fifo_read_i & ~fifo_empty_i;
  assign last_beat = req_last_i[gidx_q] | (beat_cnt_q == BW'(MAX_BURST - 1));

  always_comb begin
    req_ready_o  = '0;
    fifo_write_o = 1'b0;
    fifo_data_o  = '0;
    if (locked) begin
      req_ready_o  = grant_q & {N_REQ{~fifo_full_i}};
      fifo_write_o = req_valid_i[gidx_q] & ~fifo_full_i;
      if (fifo_write_o) fifo_data_o = req_lane[gidx_q];
    end
  end

  always_comb begin
    level_d = level_q;
    case ({fifo_write_o, rd_dec})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  assign grant_o = clear_i ? '0 : grant_q;
  assign level_o = clear_i ? '0 : level_q;
  assign afull_o = clear_i ? 1'b0 : afull_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= IW'(N_REQ - 1);
      beat_cnt_q <= '0;
      level_q    <= '0;
      afull_q    <= 1'b0;
    end else if (clear_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= IW'(N_REQ - 1);
      beat_cnt_q <= '0;
      level_q    <= '0;
      afull_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      afull_q <= (level_d >= LW'(AFULL_THRESH));
      case (state_q)
        IDLE: begin
          if (pick_valid && start_ok) begin
            grant_q    <= pick_gnt;
            gidx_q     <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= LOCKED;
          end
        end
        LOCKED: begin
          if (fifo_write_o) begin
            if (last_beat) begin
              rr_ptr_q   <= gidx_q;
              grant_q    <= '0;
              beat_cnt_q <= '0;
              state_q    <= IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + BW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Occupancy must stay within 0..SLOTS.
  always @(posedge clk) begin
    if (!rst && !clear_i) begin
      assert (!(fifo_write_o && !rd_dec && level_q == LW'(SLOTS)));
      assert (!(rd_dec && !fifo_write_o && level_q == '0));
    end
  end

endmodule
